alu_pipe: RTL

//  Registered, handshaked N-bit ALU: next generation of the combinational ALU.
//  - Accepts one operation per transfer on a valid/ready input channel.
//  - Returns the result and flags on a valid/ready output channel.
//  - Adds carry, signed-overflow and signed/unsigned compare.
//  - Adds an optional multi-cycle shift-add multiply.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mul_seq.sv | 69 ++++++
 rtl/alu_pipe.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and the flag bundle for the pipelined ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_MUL  = 3'b011,
        OP_ANDN = 3'b100,
        OP_ORN  = 3'b101,
        OP_SUB  = 3'b110,
        OP_CMP  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic eq;
        logic neq;
        logic lt;
        logic lte;
        logic gt;
        logic gte;
        logic cout;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: the first iteration runs on the start edge, so done
// pulses the cycle after the Nth iteration (N-1 edges after start); start is only legal while idle.
module alu_mul_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);
    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_in, mcand_in;
    logic [N-1:0]   mplier_q, mplier_d, mplier_in;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d, done_q, done_d;

    always_comb begin
        acc_in    = acc_q;
        mcand_in  = mcand_q;
        mplier_in = mplier_q;
        if (start) begin
            acc_in    = '0;
            mcand_in  = {{N{1'b0}}, a};
            mplier_in = b;
        end
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start || busy_q) begin
            acc_d    = mplier_in[0] ? acc_in + mcand_in : acc_in;
            mcand_d  = mcand_in << 1;
            mplier_d = mplier_in >> 1;
            cnt_d    = start ? CW'(1) : cnt_q + 1'b1;
            busy_d   = (cnt_d != CW'(N));
            done_d   = (cnt_d == CW'(N));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked registered ALU; single-cycle ops land 1 cycle after accept, MUL (ALU_PIPE_MUL_EN) N+1.
// A held result (out_valid && !out_ready) freezes the outputs and drops in_ready.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   f,
    input  logic         sgn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic [N-1:0] y_hi,
    output logic         eq,
    output logic         neq,
    output logic         lt,
    output logic         lte,
    output logic         gt,
    output logic         gte,
    output logic         cout,
    output logic         ovf
);
    alu_op_e    op;
    logic       in_fire, out_fire;
    logic       out_valid_q, out_valid_d;
    logic [N-1:0] y_q, y_d, y_hi_q, y_hi_d, y_c, b_eff;
    logic [N:0]   sum;
    alu_flags_t flags_q, flags_d, flags_c;

    assign op       = alu_op_e'(f);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // f[2] selects the inverted-b family; for SUB it also supplies the +1 carry-in.
    always_comb begin
        b_eff   = f[2] ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, f[2]};
        y_c     = '0;
        flags_c = '0;
        case (op)
            OP_AND, OP_ANDN: y_c = a & b_eff;
            OP_OR,  OP_ORN:  y_c = a | b_eff;
            OP_ADD, OP_SUB: begin
                y_c          = sum[N-1:0];
                flags_c.cout = sum[N];
                flags_c.ovf  = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_CMP: begin
                flags_c.eq  = (a == b);
                flags_c.neq = (a != b);
                flags_c.lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
                flags_c.gt  = sgn ? ($signed(a) > $signed(b)) : (a > b);
                flags_c.lte = flags_c.lt || flags_c.eq;
                flags_c.gte = flags_c.gt || flags_c.eq;
            end
            default: ;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    alu_state_e     state_q, state_d;
    logic           mul_start, mul_busy, mul_done;
    logic [2*N-1:0] mul_p;

    assign mul_start = in_fire && (op == OP_MUL);
    assign in_ready  = (state_q == S_IDLE) && !mul_busy && (!out_valid_q || out_ready);

    alu_mul_seq #(.N(N)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );
`else
    assign in_ready = !out_valid_q || out_ready;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        y_hi_d      = y_hi_q;
        flags_d     = flags_q;
        if (out_fire) out_valid_d = 1'b0;
`ifdef ALU_PIPE_MUL_EN
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    if (op == OP_MUL) begin
                        state_d = S_MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        y_d         = y_c;
                        y_hi_d      = '0;
                        flags_d     = flags_c;
                    end
                end
            end
            S_MUL: if (mul_done) state_d = S_DONE;
            S_DONE: begin
                // Wait for the result register to free up before publishing the product.
                if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    y_d         = mul_p[N-1:0];
                    y_hi_d      = mul_p[2*N-1:N];
                    flags_d     = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`else
        if (in_fire) begin
            out_valid_d = 1'b1;
            y_d         = y_c;
            y_hi_d      = '0;
            flags_d     = flags_c;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_hi_q      <= '0;
            flags_q     <= '0;
`ifdef ALU_PIPE_MUL_EN
            state_q     <= S_IDLE;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            y_hi_q      <= y_hi_d;
            flags_q     <= flags_d;
`ifdef ALU_PIPE_MUL_EN
            state_q     <= state_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign eq        = flags_q.eq;
    assign neq       = flags_q.neq;
    assign lt        = flags_q.lt;
    assign lte       = flags_q.lte;
    assign gt        = flags_q.gt;
    assign gte       = flags_q.gte;
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;

endmodule
